mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Memory-side responder for the IF and MEM stage request/status protocol.
//  Arbitrates the instruction-fetch port and the load/store port onto one byte-wide,
//  single-port RAM with 1-cycle read latency.
//  Serialises 1/2/4-byte accesses little-endian and reports progress via 2-bit status.
//  Sits between if_stage/mem_stage and the top-level RAM pins.
// PARAMETERS
//  ADDR_W  32  address width; `AddrLen
//  DATA_W  32  word width; `RegLen
// PORTS
//  clk           in   1   system clock; everything on posedge
//  rst           in   1   synchronous, active-high reset (`ResetEnable)
//  if_rw         in   1   IF read request; held high until DONE seen
//  if_addr       in   32  IF fetch address (pc)
//  if_data       out  32  fetched instruction; valid when if_status==`DONE
//  if_status     out  2   `IDLE / `BUSY / `DONE for IF port
//  ls_req        in   1   MEM-stage request; held high until DONE seen
//  ls_we         in   1   1 = store, 0 = load
//  ls_width      in   2   0 byte, 1 half, 2 word; 3 treated as word
//  ls_addr       in   32  load/store address
//  ls_wdata      in   32  store data; low bytes used per width
//  ls_rdata      out  32  load data, zero-extended; valid when ls_status==`DONE
//  ls_status     out  2   `IDLE / `BUSY / `DONE for MEM port
//  ram_a         out  32  RAM byte address
//  ram_dout      out  8   RAM write byte
//  ram_wr        out  1   RAM write strobe, 1 = write this cycle
//  ram_din       in   8   RAM read byte; valid the cycle after its address
// BEHAVIOUR
//  Reset: all outputs 0; both statuses `IDLE; FSM to S_IDLE; byte counter cleared.
//    Applies mid-transfer; a partial store is abandoned with no further writes.
//  FSM states: S_IDLE, S_RD, S_WR, S_DONE.
//  Acceptance: cycle 0 = S_IDLE with a request high.
//    ls_req wins over if_rw when both are high. IF accesses are always 4 bytes.
//    Latch addr, N = 1/2/4, we, and wdata on the accepting edge.
//  Port status:
//    Owner port reports `BUSY in every cycle from cycle 1 until DONE.
//    Non-owner port reports `IDLE and must keep its request high.
//  Read (S_RD):
//    Cycles 1..N: ram_a = addr+i-1, ram_wr = 0.
//    Cycles 2..N+1: capture ram_din into byte lane i-1.
//    Cycle N+2: S_DONE, owner status `DONE with data; e.g. word DONE in cycle 6.
//  Write (S_WR):
//    Cycles 1..N: ram_wr = 1, ram_a = addr+i-1, ram_dout = wdata[8i-1 -: 8].
//    Cycle N+1: `DONE.
//  S_DONE lasts exactly 1 cycle, then S_IDLE.
//    A request still high in that S_IDLE cycle is a new request (back-to-back allowed).
//  Data outputs hold their last value after DONE until the next capture.
//  Address arithmetic: 32-bit, wraps modulo 2^32. No alignment check; no MMIO decode.
//  ram_wr is 0 in every cycle outside S_WR.
//  Requests dropped mid-transfer are ignored; the transfer completes.
// STRUCTURE
//  `IDLE/`BUSY/`DONE, width codes (`W_BYTE/`W_HALF/`W_WORD) and `AddrLen/`RegLen
//    live in defines.v.
//  FSM state encoding is local to this module.
//  Single flat module; no sub-module needed (byte counter + 32-bit shift assembler inline).
// TESTING
//  IF read 0x1000, RAM holds 13 05 00 00 -> ram_a 0x1000..0x1003 in cycles 1..4;
//    if_status `DONE in cycle 6 with if_data=0x00000513.
//  Store word 0xDEADBEEF at 0x20 -> ram_wr=1 with bytes EF,BE,AD,DE at 0x20..0x23;
//    `DONE in cycle 5.
//  if_rw and ls_req (load byte 0x7 = 0x80) both high -> MEM served first,
//    ls_rdata=0x00000080; if_status `IDLE during it; IF served right after.
//  Load half at 0xFFFFFFFF -> second byte address wraps to 0x00000000.
//  rst asserted in cycle 2 of a word store -> next cycle ram_wr=0, both statuses `IDLE;
//    only byte 0 was written.
//  Two back-to-back IF reads -> second accepted in the S_IDLE cycle right after DONE.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, status codes and access-width codes for mem_ctrl
// Purpose: constants and helpers shared by mem_ctrl, its bus interface and the bench.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Port status codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Load/store width codes; code 3 behaves as a word
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    // Number of bytes moved for a width code
    function automatic logic [2:0] width_to_len(input logic [1:0] width);
        case (width)
            W_BYTE:  width_to_len = 3'd1;
            W_HALF:  width_to_len = 3'd2;
            default: width_to_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - IF port, MEM port and RAM pin bundle for mem_ctrl
// Purpose: groups the two requester ports and the byte-wide RAM pins.
// slave  : the controller side (requests and ram_din in; data, status, RAM drive out)
// master : the requester/RAM side (the reverse)
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              if_rw;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_data;
    logic [1:0]        if_status;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_width;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [DATA_W-1:0] ls_rdata;
    logic [1:0]        ls_status;

    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;

    modport slave (
        input  if_rw, if_addr, ls_req, ls_we, ls_width, ls_addr, ls_wdata, ram_din,
        output if_data, if_status, ls_rdata, ls_status, ram_a, ram_dout, ram_wr
    );

    modport master (
        output if_rw, if_addr, ls_req, ls_we, ls_width, ls_addr, ls_wdata, ram_din,
        input  if_data, if_status, ls_rdata, ls_status, ram_a, ram_dout, ram_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - arbitrates IF and load/store ports onto a byte-wide single-port RAM
// Purpose: serialises 1/2/4-byte little-endian accesses, load/store port has priority.
// Ports:
//   clk : system clock, posedge
//   rst : synchronous active-high reset
//   bus : mem_ctrl_if.slave - IF port, MEM port, RAM pins (1-cycle read latency)
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              owner_ls_q, owner_ls_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic [DATA_W-1:0] asm_next;
    logic [1:0]        lane;
    logic [1:0]        st;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_ls_q <= 1'b0;
            len_q      <= 3'd0;
            cnt_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_ls_q <= owner_ls_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // The byte on ram_din belongs to the address issued one count earlier,
    // so lane = cnt-1; for cnt=4 the 2-bit wrap gives lane 3.
    always_comb begin
        lane     = cnt_q[1:0] - 2'd1;
        asm_next = asm_q;
        if (cnt_q != 3'd0) begin
            asm_next[{lane, 3'b000} +: 8] = bus.ram_din;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_ls_d = owner_ls_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 3'd0;
                // Cleared so narrow loads come out zero-extended
                asm_d = '0;
                if (bus.ls_req) begin
                    owner_ls_d = 1'b1;
                    len_d      = width_to_len(bus.ls_width);
                    addr_d     = bus.ls_addr;
                    wdata_d    = bus.ls_wdata;
                    state_d    = bus.ls_we ? S_WR : S_RD;
                end else if (bus.if_rw) begin
                    owner_ls_d = 1'b0;
                    len_d      = 3'd4;
                    addr_d     = bus.if_addr;
                    state_d    = S_RD;
                end
            end
            S_RD: begin
                asm_d = asm_next;
                if (cnt_q == len_q) begin
                    state_d = S_DONE;
                    if (owner_ls_q) begin
                        ls_rdata_d = asm_next;
                    end else begin
                        if_data_d = asm_next;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WR: begin
                if (cnt_q == len_q - 3'd1) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced to zero while rst is high so that a store
    // interrupted by reset issues no write in the reset cycle.
    always_comb begin
        bus.ram_a    = '0;
        bus.ram_dout = 8'h00;
        bus.ram_wr   = 1'b0;
        st           = ST_IDLE;
        if (!rst) begin
            case (state_q)
                S_RD: begin
                    bus.ram_a = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
                    st        = ST_BUSY;
                end
                S_WR: begin
                    bus.ram_a    = addr_q + {{(ADDR_W-3){1'b0}}, cnt_q};
                    bus.ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    bus.ram_wr   = 1'b1;
                    st           = ST_BUSY;
                end
                S_DONE:  st = ST_DONE;
                default: st = ST_IDLE;
            endcase
        end
        bus.if_status = owner_ls_q ? ST_IDLE : st;
        bus.ls_status = owner_ls_q ? st : ST_IDLE;
        bus.if_data   = rst ? '0 : if_data_q;
        bus.ls_rdata  = rst ? '0 : ls_rdata_q;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] mem [0:65535];

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Byte RAM, 1-cycle read latency, indexed by the low 16 address bits
    always @(posedge clk) begin
        bus.ram_din <= mem[bus.ram_a[15:0]];
        if (bus.ram_wr) begin
            mem[bus.ram_a[15:0]] <= bus.ram_dout;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        bus.if_rw  = 1'b0;
        bus.ls_req = 1'b0;
        bus.ls_we  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1000] = 8'h13; mem[16'h1001] = 8'h05; mem[16'h1002] = 8'h00; mem[16'h1003] = 8'h00;
        mem[16'h0007] = 8'h80;
        mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
        mem[16'h0041] = 8'h55; mem[16'h0042] = 8'h55; mem[16'h0043] = 8'h55;
        mem[16'h2000] = 8'h93; mem[16'h2001] = 8'h00; mem[16'h2002] = 8'h10; mem[16'h2003] = 8'h00;
        mem[16'h2004] = 8'h13; mem[16'h2005] = 8'h01; mem[16'h2006] = 8'h20; mem[16'h2007] = 8'h00;

        rst = 1'b1;
        drop_all();
        bus.if_addr = '0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_width = W_BYTE;
        tick(); tick();
        check("rst_if_status", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        check("rst_ls_status", {30'd0, bus.ls_status}, {30'd0, ST_IDLE});
        check("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        check("rst_ram_a", bus.ram_a, 32'd0);
        check("rst_if_data", bus.if_data, 32'd0);
        check("rst_ls_rdata", bus.ls_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // IF read 0x1000
        bus.if_rw = 1'b1; bus.if_addr = 32'h1000;
        check("if_c0_status", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("if_ram_a", bus.ram_a, 32'h1000 + i - 1);
            check("if_busy", {30'd0, bus.if_status}, {30'd0, ST_BUSY});
            check("if_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        end
        tick();
        check("if_c5_busy", {30'd0, bus.if_status}, {30'd0, ST_BUSY});
        tick();
        check("if_c6_done", {30'd0, bus.if_status}, {30'd0, ST_DONE});
        check("if_c6_data", bus.if_data, 32'h00000513);
        drop_all();
        tick();
        check("if_after_idle", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        check("if_data_hold", bus.if_data, 32'h00000513);

        // Store word 0xDEADBEEF at 0x20
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_width = W_WORD;
        bus.ls_addr = 32'h20; bus.ls_wdata = 32'hDEADBEEF;
        for (int i = 1; i <= 4; i++) begin
            logic [31:0] wd;
            wd = 32'hDEADBEEF;
            tick();
            check("st_ram_wr", {31'd0, bus.ram_wr}, 32'd1);
            check("st_ram_a", bus.ram_a, 32'h20 + i - 1);
            check("st_ram_dout", {24'd0, bus.ram_dout}, {24'd0, wd[8*i-1 -: 8]});
            check("st_busy", {30'd0, bus.ls_status}, {30'd0, ST_BUSY});
        end
        tick();
        check("st_c5_done", {30'd0, bus.ls_status}, {30'd0, ST_DONE});
        check("st_c5_wr0", {31'd0, bus.ram_wr}, 32'd0);
        drop_all();
        tick();
        check("st_mem", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'hDEADBEEF);

        // Both requests high: load byte 0x7 wins, then IF read
        bus.if_rw = 1'b1; bus.if_addr = 32'h1000;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_width = W_BYTE; bus.ls_addr = 32'h7;
        tick();
        check("arb_ls_busy", {30'd0, bus.ls_status}, {30'd0, ST_BUSY});
        check("arb_if_idle1", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        check("arb_ram_a", bus.ram_a, 32'h7);
        tick();
        check("arb_if_idle2", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        tick();
        check("arb_ls_done", {30'd0, bus.ls_status}, {30'd0, ST_DONE});
        check("arb_ls_rdata", bus.ls_rdata, 32'h00000080);
        check("arb_if_idle3", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        bus.ls_req = 1'b0;
        tick();
        tick();
        check("arb_if_busy", {30'd0, bus.if_status}, {30'd0, ST_BUSY});
        check("arb_if_ram_a", bus.ram_a, 32'h1000);
        for (int i = 0; i < 5; i++) tick();
        check("arb_if_done", {30'd0, bus.if_status}, {30'd0, ST_DONE});
        check("arb_if_data", bus.if_data, 32'h00000513);
        drop_all();
        tick();

        // Load word at 0x20, then half at 0xFFFFFFFF (address wrap, zero-extend)
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_width = W_WORD; bus.ls_addr = 32'h20;
        for (int i = 0; i < 6; i++) tick();
        check("lw_done", {30'd0, bus.ls_status}, {30'd0, ST_DONE});
        check("lw_rdata", bus.ls_rdata, 32'hDEADBEEF);
        drop_all();
        tick();
        bus.ls_req = 1'b1; bus.ls_width = W_HALF; bus.ls_addr = 32'hFFFFFFFF;
        tick();
        check("lh_ram_a0", bus.ram_a, 32'hFFFFFFFF);
        tick();
        check("lh_ram_a1", bus.ram_a, 32'h00000000);
        tick();
        check("lh_busy", {30'd0, bus.ls_status}, {30'd0, ST_BUSY});
        tick();
        check("lh_done", {30'd0, bus.ls_status}, {30'd0, ST_DONE});
        check("lh_rdata", bus.ls_rdata, 32'h00001234);
        drop_all();
        tick();

        // Reset during cycle 2 of a word store
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_width = W_WORD;
        bus.ls_addr = 32'h40; bus.ls_wdata = 32'hCAFEF00D;
        tick();
        check("rs_c1_wr", {31'd0, bus.ram_wr}, 32'd1);
        tick();
        rst = 1'b1;
        drop_all();
        #1;
        check("rs_c2_wr", {31'd0, bus.ram_wr}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rs_c3_wr", {31'd0, bus.ram_wr}, 32'd0);
        check("rs_ls_idle", {30'd0, bus.ls_status}, {30'd0, ST_IDLE});
        check("rs_if_idle", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        check("rs_if_data", bus.if_data, 32'd0);
        tick();
        check("rs_c4_wr", {31'd0, bus.ram_wr}, 32'd0);
        check("rs_mem", {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]}, 32'h5555550D);

        // Back-to-back IF reads
        bus.if_rw = 1'b1; bus.if_addr = 32'h2000;
        for (int i = 0; i < 6; i++) tick();
        check("b2b_done1", {30'd0, bus.if_status}, {30'd0, ST_DONE});
        check("b2b_data1", bus.if_data, 32'h00100093);
        bus.if_addr = 32'h2004;
        tick();
        check("b2b_idle", {30'd0, bus.if_status}, {30'd0, ST_IDLE});
        tick();
        check("b2b_busy", {30'd0, bus.if_status}, {30'd0, ST_BUSY});
        check("b2b_ram_a", bus.ram_a, 32'h2004);
        for (int i = 0; i < 5; i++) tick();
        check("b2b_done2", {30'd0, bus.if_status}, {30'd0, ST_DONE});
        check("b2b_data2", bus.if_data, 32'h00200113);
        drop_all();
        tick();
        check("b2b_end_idle", {30'd0, bus.if_status}, {30'd0, ST_IDLE});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
